// File: rtl/frec_div_ctrl.sv
// frec_div_ctrl: run/stop and boundary-synchronised reconfiguration controller for a toggle clock divider
module frec_div_ctrl #(
    parameter int WIDTH       = 6,
    parameter int DEFAULT_DIV = 49
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Enable,
    input  logic [WIDTH-1:0] Div_In,
    input  logic             Load_Req,
    output logic             Load_Ack,
    output logic             Pending,
    output logic             Running,
    output logic             Tick,
    output logic             DivCLK
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] shadow_q;
    logic             divclk_q;
    logic             tick_q;
    logic             ack_q;
    logic             pend_q;
    logic             wrap;
    logic             capture;
    logic             apply;
    // A wrap is a period boundary; the divisor may only change there (or in IDLE) so q never exceeds it
    assign wrap    = (state_q != IDLE) && (q_q == div_q);
    assign capture = Load_Req && !pend_q && !ack_q;
    assign apply   = pend_q && ((state_q == IDLE) || wrap);
    assign Load_Ack = ack_q;
    assign Pending  = pend_q;
    assign Running  = (state_q != IDLE);
    assign Tick     = tick_q;
    assign DivCLK   = divclk_q;
    // Run/stop FSM, divider counter and divisor load handshake
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            q_q      <= '0;
            div_q    <= WIDTH'(DEFAULT_DIV);
            shadow_q <= '0;
            divclk_q <= 1'b0;
            tick_q   <= 1'b0;
            ack_q    <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            tick_q <= wrap;
            ack_q  <= apply;
            pend_q <= capture || (pend_q && !apply);
            if (capture) shadow_q <= Div_In;
            if (apply) div_q <= shadow_q;
            case (state_q)
                IDLE: begin
                    q_q      <= '0;
                    divclk_q <= 1'b0;
                    if (Enable) state_q <= RUN;
                end
                RUN: begin
                    q_q <= wrap ? '0 : q_q + WIDTH'(1);
                    if (wrap) divclk_q <= ~divclk_q;
                    if (!Enable) state_q <= STOP;
                end
                STOP: begin
                    q_q <= wrap ? '0 : q_q + WIDTH'(1);
                    if (Enable) begin
                        state_q <= RUN;
                        if (wrap) divclk_q <= ~divclk_q;
                    end else if (wrap) begin
                        divclk_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_frec_div_ctrl.sv
// tb_frec_div_ctrl: directed table and sequence checks for frec_div_ctrl
module tb_frec_div_ctrl;
    logic       CLK = 1'b0;
    logic       Reset = 1'b0;
    logic       Enable = 1'b0;
    logic [5:0] Div_In = '0;
    logic       Load_Req = 1'b0;
    logic       Load_Ack, Pending, Running, Tick, DivCLK;
    logic [4:0] obs;
    int checks = 0;
    int errors = 0;
    logic ack_seen, hi_seen;

    typedef struct {
        logic       en;
        logic       req;
        logic [5:0] div;
        logic [4:0] exp;
    } vec_t;
    vec_t tbl[5];

    frec_div_ctrl #(.WIDTH(6), .DEFAULT_DIV(49)) dut (
        .CLK(CLK), .Reset(Reset), .Enable(Enable), .Div_In(Div_In), .Load_Req(Load_Req),
        .Load_Ack(Load_Ack), .Pending(Pending), .Running(Running), .Tick(Tick), .DivCLK(DivCLK)
    );

    always #5 CLK = ~CLK;
    assign obs = {Load_Ack, Pending, Running, Tick, DivCLK};

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        ack_seen = ack_seen | Load_Ack;
        hi_seen  = hi_seen | DivCLK;
    endtask

    // sel 0: wait for Tick, 1: wait for Load_Ack, 2: wait for Running low
    task automatic wait_sig(input int sel, output int n);
        logic hit;
        n = 0;
        do begin
            step();
            n++;
            hit = (sel == 0) ? Tick : (sel == 1) ? Load_Ack : !Running;
        end while (!hit && n < 300);
    endtask

    initial begin
        int n;
        ack_seen = 1'b0;
        hi_seen  = 1'b0;
        tbl[0] = '{en: 1'b0, req: 1'b1, div: 6'd9, exp: 5'b01000};
        tbl[1] = '{en: 1'b0, req: 1'b1, div: 6'd9, exp: 5'b10000};
        tbl[2] = '{en: 1'b0, req: 1'b1, div: 6'd3, exp: 5'b00000};
        tbl[3] = '{en: 1'b0, req: 1'b0, div: 6'd3, exp: 5'b00000};
        tbl[4] = '{en: 1'b1, req: 1'b0, div: 6'd3, exp: 5'b00100};
        #3;
        chk("reset_outputs", int'(obs), 0);
        repeat (2) @(negedge CLK);
        Reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            Enable = tbl[i].en;
            Load_Req = tbl[i].req;
            Div_In = tbl[i].div;
            step();
            chk($sformatf("idle_vec%0d", i), int'(obs), int'(tbl[i].exp));
        end
        wait_sig(0, n);
        chk("div9_first_half", n, 10);
        chk("div9_rise", int'(DivCLK), 1);
        wait_sig(0, n);
        chk("div9_second_half", n, 10);
        chk("div9_fall", int'(DivCLK), 0);
        repeat (3) step();
        Load_Req = 1'b1;
        Div_In = 6'd4;
        step();
        chk("run_capture", int'({Load_Ack, Pending}), 1);
        wait_sig(1, n);
        chk("run_apply_delay", n, 6);
        chk("apply_tick_divclk", int'({Tick, DivCLK}), 3);
        Load_Req = 1'b0;
        wait_sig(0, n);
        chk("div4_half_a", n, 5);
        chk("div4_fall", int'(DivCLK), 0);
        wait_sig(0, n);
        chk("div4_half_b", n, 5);
        chk("div4_rise", int'(DivCLK), 1);
        Enable = 1'b0;
        step();
        chk("stop_entered", int'({Running, DivCLK}), 3);
        wait_sig(2, n);
        chk("stop_high_wrap", n, 4);
        chk("stop_high_fall", int'(DivCLK), 0);
        repeat (3) step();
        chk("idle_held", int'(obs), 0);
        Enable = 1'b1;
        step();
        Enable = 1'b0;
        hi_seen = 1'b0;
        step();
        wait_sig(2, n);
        chk("stop_low_wrap", n, 4);
        chk("stop_low_never_high", int'({hi_seen, DivCLK}), 0);
        Load_Req = 1'b1;
        Div_In = 6'd0;
        step();
        chk("div0_capture", int'(obs), 5'b01000);
        step();
        chk("div0_ack", int'(obs), 5'b10000);
        Load_Req = 1'b0;
        Enable = 1'b1;
        step();
        chk("div0_start", int'(obs), 5'b00100);
        for (int i = 1; i <= 6; i++) begin
            step();
            chk($sformatf("div0_cycle%0d", i), int'({Tick, DivCLK}), 2 + (i % 2));
        end
        Enable = 1'b0;
        step();
        wait_sig(2, n);
        chk("div0_stop", n, 1);
        chk("div0_stop_low", int'(DivCLK), 0);
        Enable = 1'b1;
        step();
        Load_Req = 1'b1;
        Div_In = 6'd20;
        step();
        chk("pend_and_high", int'({Pending, DivCLK}), 3);
        #2;
        Reset = 1'b0;
        #1;
        chk("async_reset_outputs", int'(obs), 0);
        ack_seen = 1'b0;
        @(negedge CLK);
        Reset = 1'b1;
        Load_Req = 1'b0;
        Enable = 1'b1;
        step();
        wait_sig(0, n);
        chk("default_rise", n, 50);
        chk("default_rise_level", int'(DivCLK), 1);
        wait_sig(0, n);
        chk("default_fall", n, 50);
        chk("default_fall_level", int'(DivCLK), 0);
        chk("no_ack_after_reset", int'(ack_seen), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
